// File: rtl/exec_seg_scheduler.sv
// Segment scheduler for the buffer command executor: queues host segment addresses,
// launches them one at a time, checks completion codes and supervises run time.
module exec_seg_scheduler #(
    parameter int          QDEPTH_LOG2 = 3,
    parameter logic [31:0] TIMEOUT     = 32'd0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run_en,
    input  logic                   seg_push,
    input  logic [15:0]            seg_push_addr,
    input  logic                   abort_req,
    input  logic                   clear_fault,
    output logic [QDEPTH_LOG2:0]   seg_count,
    output logic                   seg_full,
    output logic                   exec_start,
    output logic [15:0]            exec_start_addr,
    output logic                   exec_abort,
    input  logic                   exec_complete,
    input  logic [7:0]             exec_error,
    input  logic [15:0]            exec_pc,
    output logic                   busy,
    output logic                   fault,
    output logic [7:0]             fault_code,
    output logic [15:0]            fault_pc,
    output logic                   push_ovf,
    output logic [31:0]            segs_done,
    output logic                   irq_drained
);

    localparam int                       DEPTH    = 1 << QDEPTH_LOG2;
    localparam logic [QDEPTH_LOG2:0]     FULL_CNT = (QDEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [QDEPTH_LOG2:0]     CNT_ONE  = (QDEPTH_LOG2 + 1)'(1);
    localparam logic [QDEPTH_LOG2-1:0]   PTR_ONE  = (QDEPTH_LOG2)'(1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    localparam logic [7:0] CODE_OK    = 8'h7F;
    localparam logic [7:0] CODE_ABORT = 8'h82;
    localparam logic [7:0] CODE_WDOG  = 8'h83;

    logic [2:0]               r_state;
    logic [15:0]              r_mem [DEPTH];
    logic [QDEPTH_LOG2-1:0]   r_wr_ptr;
    logic [QDEPTH_LOG2-1:0]   r_rd_ptr;
    logic [QDEPTH_LOG2:0]     r_count;
    logic                     r_full;
    logic                     r_start;
    logic [15:0]              r_start_addr;
    logic                     r_abort;
    logic                     r_busy;
    logic                     r_fault;
    logic [7:0]               r_fault_code;
    logic [15:0]              r_fault_pc;
    logic                     r_push_ovf;
    logic [31:0]              r_segs_done;
    logic                     r_irq;
    logic [31:0]              r_wdog;

    logic [2:0]               w_next_state;
    logic                     w_pop;
    logic                     w_abort_pulse;
    logic                     w_set_fault;
    logic [7:0]               w_new_code;
    logic                     w_done_ok;
    logic                     w_clear;
    logic                     w_push_ok;
    logic                     w_push_drop;
    logic [QDEPTH_LOG2:0]     w_count_next;

    // Next-state decode; abort_req overrides every other event.
    always_comb begin
        w_next_state  = r_state;
        w_pop         = 1'b0;
        w_abort_pulse = 1'b0;
        w_set_fault   = 1'b0;
        w_new_code    = r_fault_code;
        w_done_ok     = 1'b0;
        w_clear       = 1'b0;
        if (abort_req) begin
            if ((r_state == S_START) || (r_state == S_RUN) || (r_state == S_CHECK)) begin
                w_next_state  = S_FAULT;
                w_abort_pulse = 1'b1;
                w_set_fault   = 1'b1;
                w_new_code    = CODE_ABORT;
            end else begin
                w_next_state  = r_state;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (run_en && (r_count != '0)) begin
                        w_pop        = 1'b1;
                        w_next_state = S_START;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
                S_START: w_next_state = S_RUN;
                S_RUN: begin
                    if (exec_complete) begin
                        w_next_state = S_CHECK;
                    end else if ((TIMEOUT != 32'd0) && (r_wdog == (TIMEOUT - 32'd1))) begin
                        w_next_state  = S_FAULT;
                        w_abort_pulse = 1'b1;
                        w_set_fault   = 1'b1;
                        w_new_code    = CODE_WDOG;
                    end else begin
                        w_next_state = S_RUN;
                    end
                end
                S_CHECK: begin
                    if (exec_error == CODE_OK) begin
                        w_done_ok    = 1'b1;
                        w_next_state = S_IDLE;
                    end else begin
                        w_next_state = S_FAULT;
                        w_set_fault  = 1'b1;
                        w_new_code   = exec_error;
                    end
                end
                S_FAULT: begin
                    if (clear_fault) begin
                        w_clear      = 1'b1;
                        w_next_state = S_IDLE;
                    end else begin
                        w_next_state = S_FAULT;
                    end
                end
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // Queue occupancy; a flush discards any same-cycle push.
    always_comb begin
        w_push_ok   = seg_push && !abort_req && (r_count != FULL_CNT);
        w_push_drop = seg_push && !abort_req && (r_count == FULL_CNT);
        if (abort_req) begin
            w_count_next = '0;
        end else if (w_push_ok && !w_pop) begin
            w_count_next = r_count + CNT_ONE;
        end else if (!w_push_ok && w_pop) begin
            w_count_next = r_count - CNT_ONE;
        end else begin
            w_count_next = r_count;
        end
    end

    // Queue storage; contents are don't-care while not counted.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= seg_push_addr;
        end else begin
            r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
        end
    end

    // State, queue pointers, watchdog and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_full       <= 1'b0;
            r_start      <= 1'b0;
            r_start_addr <= 16'h0000;
            r_abort      <= 1'b0;
            r_busy       <= 1'b0;
            r_fault      <= 1'b0;
            r_fault_code <= 8'h00;
            r_fault_pc   <= 16'h0000;
            r_push_ovf   <= 1'b0;
            r_segs_done  <= 32'd0;
            r_irq        <= 1'b0;
            r_wdog       <= 32'd0;
        end else begin
            r_state <= w_next_state;
            r_count <= w_count_next;
            r_full  <= (w_count_next == FULL_CNT);
            r_start <= (w_next_state == S_START);
            r_abort <= w_abort_pulse;
            r_busy  <= (w_next_state != S_IDLE);
            r_fault <= (w_next_state == S_FAULT);
            r_irq   <= w_done_ok && (w_count_next == '0);

            if (abort_req) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push_ok) begin
                    r_wr_ptr <= r_wr_ptr + PTR_ONE;
                end else begin
                    r_wr_ptr <= r_wr_ptr;
                end
                if (w_pop) begin
                    r_rd_ptr     <= r_rd_ptr + PTR_ONE;
                    r_start_addr <= r_mem[r_rd_ptr];
                end else begin
                    r_rd_ptr     <= r_rd_ptr;
                end
            end

            if (r_state == S_START) begin
                r_wdog <= 32'd0;
            end else if (r_state == S_RUN) begin
                r_wdog <= r_wdog + 32'd1;
            end else begin
                r_wdog <= r_wdog;
            end

            if (w_set_fault) begin
                r_fault_code <= w_new_code;
                r_fault_pc   <= exec_pc;
            end else if (w_clear) begin
                r_fault_code <= 8'h00;
                r_fault_pc   <= 16'h0000;
            end else begin
                r_fault_code <= r_fault_code;
                r_fault_pc   <= r_fault_pc;
            end

            // A fresh overflow outranks the clear so it is never lost.
            if (w_push_drop) begin
                r_push_ovf <= 1'b1;
            end else if (w_clear) begin
                r_push_ovf <= 1'b0;
            end else begin
                r_push_ovf <= r_push_ovf;
            end

            if (w_done_ok) begin
                r_segs_done <= r_segs_done + 32'd1;
            end else begin
                r_segs_done <= r_segs_done;
            end
        end
    end

    assign seg_count       = r_count;
    assign seg_full        = r_full;
    assign exec_start      = r_start;
    assign exec_start_addr = r_start_addr;
    assign exec_abort      = r_abort;
    assign busy            = r_busy;
    assign fault           = r_fault;
    assign fault_code      = r_fault_code;
    assign fault_pc        = r_fault_pc;
    assign push_ovf        = r_push_ovf;
    assign segs_done       = r_segs_done;
    assign irq_drained     = r_irq;

endmodule

// File: tb/tb_exec_seg_scheduler.sv
// Directed bench for exec_seg_scheduler: output pulses are checked against a
// scoreboard of expected events; status registers are checked inline.
module tb_exec_seg_scheduler;

    localparam int EV_START = 0;
    localparam int EV_ABORT = 1;
    localparam int EV_IRQ   = 2;

    typedef struct {
        int          kind;
        logic [15:0] data;
        logic [7:0]  code;
        int          delta;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        run_en;
    logic        seg_push;
    logic [15:0] seg_push_addr;
    logic        abort_req;
    logic        clear_fault;
    logic [3:0]  seg_count;
    logic        seg_full;
    logic        exec_start;
    logic [15:0] exec_start_addr;
    logic        exec_abort;
    logic        exec_complete;
    logic [7:0]  exec_error;
    logic [15:0] exec_pc;
    logic        busy;
    logic        fault;
    logic [7:0]  fault_code;
    logic [15:0] fault_pc;
    logic        push_ovf;
    logic [31:0] segs_done;
    logic        irq_drained;

    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc      = 0;
    int  start_cyc = 0;
    bit  mon_en   = 1'b0;
    ev_t sb[$];

    exec_seg_scheduler #(.QDEPTH_LOG2(3), .TIMEOUT(32'd100)) dut (
        .clk(clk), .rst(rst), .run_en(run_en), .seg_push(seg_push),
        .seg_push_addr(seg_push_addr), .abort_req(abort_req), .clear_fault(clear_fault),
        .seg_count(seg_count), .seg_full(seg_full), .exec_start(exec_start),
        .exec_start_addr(exec_start_addr), .exec_abort(exec_abort),
        .exec_complete(exec_complete), .exec_error(exec_error), .exec_pc(exec_pc),
        .busy(busy), .fault(fault), .fault_code(fault_code), .fault_pc(fault_pc),
        .push_ovf(push_ovf), .segs_done(segs_done), .irq_drained(irq_drained)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_ev(input int kind, input logic [15:0] data, input logic [7:0] code,
                             input int delta);
        ev_t e;
        e.kind = kind; e.data = data; e.code = code; e.delta = delta;
        sb.push_back(e);
    endtask

    task automatic check_ev(input int kind);
        ev_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d expected none (t=%0t)", kind, $time);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind) begin
                n_fail++;
                $display("FAIL event_kind: got %0d expected %0d (t=%0t)", kind, e.kind, $time);
            end else if (kind == EV_START) begin
                chk("start_addr", 32'(exec_start_addr), 32'(e.data));
                start_cyc = cyc;
            end else if (kind == EV_ABORT) begin
                chk("abort_code", 32'(fault_code), 32'(e.code));
                chk("abort_pc", 32'(fault_pc), 32'(e.data));
                if (e.delta >= 0) chk("wdog_delay", 32'(cyc - start_cyc), 32'(e.delta));
            end
        end
    endtask

    // Monitor: every output pulse must match the next expected event.
    always @(negedge clk) begin
        if (mon_en) begin
            if (exec_start === 1'b1 && exec_abort === 1'b1) chk("start_abort_overlap", 32'd1, 32'd0);
            if (exec_start === 1'b1) check_ev(EV_START);
            if (exec_abort === 1'b1) check_ev(EV_ABORT);
            if (irq_drained === 1'b1) check_ev(EV_IRQ);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] a);
        seg_push = 1'b1;
        seg_push_addr = a;
        tick();
        seg_push = 1'b0;
    endtask

    task automatic wait_start();
        bit found = 1'b0;
        int n = 0;
        while (!found && n < 100) begin
            @(negedge clk);
            if (exec_start === 1'b1) found = 1'b1;
            n++;
        end
        chk("start_seen", 32'(found), 32'd1);
    endtask

    // Executor model: completes after lat RUN cycles, error code one cycle later.
    task automatic finish_run(input logic [7:0] err, input logic [15:0] pc, input int lat);
        @(posedge clk); #1;
        repeat (lat - 1) @(posedge clk);
        #1;
        exec_complete = 1'b1;
        exec_pc = pc;
        tick();
        exec_complete = 1'b0;
        exec_error = err;
        tick();
        exec_error = 8'h00;
    endtask

    task automatic do_clear();
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; run_en = 1'b0; seg_push = 1'b0; seg_push_addr = 16'h0000;
        abort_req = 1'b0; clear_fault = 1'b0; exec_complete = 1'b0;
        exec_error = 8'h00; exec_pc = 16'h0000;
        repeat (3) tick();
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(seg_count), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_segs_done", segs_done, 32'd0);
        chk("rst_start_addr", 32'(exec_start_addr), 32'd0);

        // Two good segments back to back
        expect_ev(EV_START, 16'h0010, 8'h00, -1);
        expect_ev(EV_START, 16'h0040, 8'h00, -1);
        expect_ev(EV_IRQ,   16'h0000, 8'h00, -1);
        push(16'h0010);
        push(16'h0040);
        @(negedge clk);
        chk("t1_count", 32'(seg_count), 32'd2);
        run_en = 1'b1;
        wait_start();
        finish_run(8'h7F, 16'h0000, 3);
        wait_start();
        finish_run(8'h7F, 16'h0000, 3);
        repeat (3) @(negedge clk);
        chk("t1_segs_done", segs_done, 32'd2);
        chk("t1_count_end", 32'(seg_count), 32'd0);
        chk("t1_busy_end", 32'(busy), 32'd0);

        // Bad completion code freezes in FAULT with the queue kept
        run_en = 1'b0;
        expect_ev(EV_START, 16'h0100, 8'h00, -1);
        expect_ev(EV_START, 16'h0200, 8'h00, -1);
        push(16'h0100);
        push(16'h0200);
        push(16'h0300);
        @(negedge clk);
        run_en = 1'b1;
        wait_start();
        finish_run(8'h7F, 16'h0000, 2);
        wait_start();
        finish_run(8'h81, 16'h0045, 2);
        @(negedge clk);
        chk("t2_fault", 32'(fault), 32'd1);
        chk("t2_code", 32'(fault_code), 32'h81);
        chk("t2_pc", 32'(fault_pc), 32'h45);
        chk("t2_count", 32'(seg_count), 32'd1);
        chk("t2_busy", 32'(busy), 32'd1);
        repeat (3) @(negedge clk);
        chk("t2_no_launch_in_fault", 32'(seg_count), 32'd1);
        expect_ev(EV_START, 16'h0300, 8'h00, -1);
        expect_ev(EV_IRQ,   16'h0000, 8'h00, -1);
        do_clear();
        @(negedge clk);
        chk("t2_cleared_fault", 32'(fault), 32'd0);
        chk("t2_cleared_code", 32'(fault_code), 32'd0);
        chk("t2_cleared_pc", 32'(fault_pc), 32'd0);
        wait_start();
        finish_run(8'h7F, 16'h0000, 2);
        repeat (2) @(negedge clk);
        chk("t2_segs_done", segs_done, 32'd4);

        // Watchdog: executor never completes
        exec_pc = 16'h0777;
        expect_ev(EV_START, 16'h0500, 8'h00, -1);
        expect_ev(EV_ABORT, 16'h0777, 8'h83, 101);
        push(16'h0500);
        wait_start();
        begin
            int n = 0;
            while (fault !== 1'b1 && n < 300) begin
                @(negedge clk);
                n++;
            end
        end
        chk("t3_fault", 32'(fault), 32'd1);
        chk("t3_code", 32'(fault_code), 32'h83);
        do_clear();
        @(negedge clk);
        chk("t3_cleared", 32'(fault), 32'd0);

        // Queue full / overflow / simultaneous push and pop
        run_en = 1'b0;
        for (int i = 0; i < 7; i++) push(16'h1000 + 16'(i));
        @(negedge clk);
        chk("t4_count7", 32'(seg_count), 32'd7);
        chk("t4_not_full", 32'(seg_full), 32'd0);
        expect_ev(EV_START, 16'h1000, 8'h00, -1);
        seg_push = 1'b1;
        seg_push_addr = 16'h10FF;
        run_en = 1'b1;
        tick();
        seg_push = 1'b0;
        run_en = 1'b0;
        wait_start();
        chk("t4_push_pop_count", 32'(seg_count), 32'd7);
        finish_run(8'h7F, 16'h0000, 2);
        repeat (2) @(negedge clk);
        chk("t4_no_relaunch", 32'(busy), 32'd0);
        push(16'h1100);
        @(negedge clk);
        chk("t4_count8", 32'(seg_count), 32'd8);
        chk("t4_full", 32'(seg_full), 32'd1);
        chk("t4_ovf_clear", 32'(push_ovf), 32'd0);
        push(16'h1200);
        @(negedge clk);
        chk("t4_ovf", 32'(push_ovf), 32'd1);
        chk("t4_count_kept", 32'(seg_count), 32'd8);
        abort_req = 1'b1;
        tick();
        abort_req = 1'b0;
        @(negedge clk);
        chk("t4_flush_count", 32'(seg_count), 32'd0);
        chk("t4_flush_full", 32'(seg_full), 32'd0);
        chk("t4_flush_nofault", 32'(fault), 32'd0);

        // Abort coinciding with completion during RUN
        push(16'h2000);
        push(16'h2100);
        push(16'h2200);
        @(negedge clk);
        chk("t5_count3", 32'(seg_count), 32'd3);
        expect_ev(EV_START, 16'h2000, 8'h00, -1);
        expect_ev(EV_ABORT, 16'h0999, 8'h82, -1);
        run_en = 1'b1;
        wait_start();
        chk("t5_count2", 32'(seg_count), 32'd2);
        @(posedge clk); #1;
        exec_complete = 1'b1;
        abort_req = 1'b1;
        exec_pc = 16'h0999;
        tick();
        exec_complete = 1'b0;
        abort_req = 1'b0;
        @(negedge clk);
        chk("t5_fault", 32'(fault), 32'd1);
        chk("t5_count0", 32'(seg_count), 32'd0);
        repeat (3) @(negedge clk);
        chk("t5_segs_done", segs_done, 32'd5);
        run_en = 1'b0;
        do_clear();

        // Synchronous reset during RUN
        expect_ev(EV_START, 16'h3000, 8'h00, -1);
        push(16'h3000);
        push(16'h3100);
        run_en = 1'b1;
        wait_start();
        @(posedge clk); #1;
        rst = 1'b1;
        tick();
        run_en = 1'b0;
        @(negedge clk);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_count", 32'(seg_count), 32'd0);
        chk("t6_segs_done", segs_done, 32'd0);
        chk("t6_ovf", 32'(push_ovf), 32'd0);
        chk("t6_abort", 32'(exec_abort), 32'd0);
        chk("t6_start", 32'(exec_start), 32'd0);
        tick();
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
